pc_fetch_unit: RTL and testbench

Parametrised fetch-stage program counter for the pipelined RISC-V core, replacing the single-cycle PC register. It computes the next fetch address and holds the IF/ID pipeline register. It resolves branch, jal and jalr redirects from EX, supports stall and flush, and optionally predicts taken branches with a direct-mapped branch target buffer (BTB). It sits between instruction memory and the decode stage.

---
 rtl/pc_fetch_unit.sv | 120 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with IF/ID register and EX-resolved redirects.
// Optional direct-mapped BTB is compiled in when PC_FETCH_BTB_EN is defined.
module pc_fetch_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  BTB_ENTRIES  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [31:0]         instr_f,
  input  logic                ex_valid,
  input  logic                ex_taken,
  input  logic                ex_jump_reg,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [PC_WIDTH-1:0] ex_imm,
  input  logic [PC_WIDTH-1:0] ex_rs1,
  input  logic                ex_pred_taken,
  input  logic [PC_WIDTH-1:0] ex_pred_target,
  output logic [PC_WIDTH-1:0] pc_f,
  output logic                redirect,
  output logic                id_valid,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc,
  output logic [PC_WIDTH-1:0] id_pc_plus4,
  output logic                id_pred_taken,
  output logic [PC_WIDTH-1:0] id_pred_target
);

  localparam logic [PC_WIDTH-1:0] FOUR = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] LSB_CLR = ~PC_WIDTH'(1);

  if (BTB_ENTRIES < 2 || (BTB_ENTRIES & (BTB_ENTRIES - 1)) != 0) begin : g_bad_btb_entries
    $error("BTB_ENTRIES must be a power of two and at least 2");
  end

  logic [PC_WIDTH-1:0] pc_plus4_f;
  logic [PC_WIDTH-1:0] pred_next_f;
  logic                pred_taken_f;
  logic [PC_WIDTH-1:0] actual_target_ex;
  logic [PC_WIDTH-1:0] actual_next_ex;

  // EX stage: resolve the real control-flow target and compare with the prediction
  assign pc_plus4_f       = pc_f + FOUR;
  assign actual_target_ex = ex_jump_reg ? ((ex_rs1 + ex_imm) & LSB_CLR) : (ex_pc + ex_imm);
  assign actual_next_ex   = ex_taken ? actual_target_ex : (ex_pc + FOUR);
  assign redirect = ex_valid &&
                    ((ex_taken != ex_pred_taken) ||
                     (ex_taken && (actual_target_ex != ex_pred_target)));

`ifdef PC_FETCH_BTB_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_WIDTH - 2 - IDX_W;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [IDX_W-1:0] idx_ex;
  logic [TAG_W-1:0] tag_ex;
  logic             hit_f;

  assign idx_f  = pc_f[2 +: IDX_W];
  assign tag_f  = pc_f[PC_WIDTH-1 -: TAG_W];
  assign idx_ex = ex_pc[2 +: IDX_W];
  assign tag_ex = ex_pc[PC_WIDTH-1 -: TAG_W];
  assign hit_f  = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);

  assign pred_taken_f = hit_f;
  assign pred_next_f  = hit_f ? btb_target[idx_f] : pc_plus4_f;

  // BTB training ignores stall: resolution in EX is independent of fetch holding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (ex_valid && ex_taken) begin
      btb_valid[idx_ex] <= 1'b1;
    end else if (ex_valid && ex_pred_taken) begin
      btb_valid[idx_ex] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ex_valid && ex_taken) begin
      btb_tag[idx_ex]    <= tag_ex;
      btb_target[idx_ex] <= actual_target_ex;
    end
  end
`else
  assign pred_taken_f = 1'b0;
  assign pred_next_f  = pc_plus4_f;
`endif

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f           <= RESET_VECTOR;
      id_valid       <= 1'b0;
      id_instr       <= '0;
      id_pc          <= '0;
      id_pc_plus4    <= '0;
      id_pred_taken  <= 1'b0;
      id_pred_target <= '0;
    end else if (redirect) begin
      pc_f     <= actual_next_ex;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc_f           <= pred_next_f;
      id_valid       <= 1'b1;
      id_instr       <= instr_f;
      id_pc          <= pc_f;
      id_pc_plus4    <= pc_plus4_f;
      id_pred_taken  <= pred_taken_f;
      id_pred_target <= pred_next_f;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic against a
// cycle-level reference model (BTB checks when PC_FETCH_BTB_EN is defined).
module tb_pc_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] instr_f = '0;
  logic        ex_valid = 1'b0, ex_taken = 1'b0, ex_jump_reg = 1'b0, ex_pred_taken = 1'b0;
  logic [31:0] ex_pc = '0, ex_imm = '0, ex_rs1 = '0, ex_pred_target = '0;
  logic [31:0] pc_f, id_instr, id_pc, id_pc_plus4, id_pred_target;
  logic        redirect, id_valid, id_pred_taken;

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_WIDTH(32), .RESET_VECTOR(RV), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_f(instr_f),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_jump_reg(ex_jump_reg),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .pc_f(pc_f), .redirect(redirect), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_pred_taken(id_pred_taken),
    .id_pred_target(id_pred_target)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_idpc, m_plus4, m_ptgt;
  logic        m_valid, m_ptaken;
`ifdef PC_FETCH_BTB_EN
  logic        m_bv   [16];
  logic [31:0] m_bpc  [16];
  logic [31:0] m_btgt [16];
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0; ex_jump_reg = 1'b0;
    ex_pred_taken = 1'b0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0; ex_pred_target = '0;
  endtask

  task automatic model_reset();
    m_pc = RV; m_valid = 1'b0; m_instr = '0; m_idpc = '0; m_plus4 = '0;
    m_ptaken = 1'b0; m_ptgt = '0;
`ifdef PC_FETCH_BTB_EN
    for (int i = 0; i < 16; i++) begin
      m_bv[i] = 1'b0; m_bpc[i] = '0; m_btgt[i] = '0;
    end
`endif
  endtask

  // Called shortly after a negedge; asserts rst away from any rising edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    chk({tag, ".pc_f"}, pc_f, RV);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, ".id_instr"}, id_instr, 32'd0);
    chk({tag, ".id_pc"}, id_pc, 32'd0);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4, 32'd0);
    chk({tag, ".id_pred"}, {id_pred_target[30:0], id_pred_taken}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: compare DUT to the model, then advance the model over the edge.
  task automatic step(input string tag);
    logic [31:0] tgt, nxt, pnext;
    logic        ptk, redir;
    int          s;
    #1;
    tgt   = ex_jump_reg ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    nxt   = ex_taken ? tgt : ex_pc + 32'd4;
    redir = ex_valid && ((ex_taken != ex_pred_taken) || (ex_taken && tgt != ex_pred_target));
    ptk   = 1'b0;
    pnext = m_pc + 32'd4;
    s     = 0;
`ifdef PC_FETCH_BTB_EN
    s = int'((m_pc >> 2) % 16);
    if (m_bv[s] && ((m_bpc[s] >> 2) == (m_pc >> 2))) begin
      ptk = 1'b1;
      pnext = m_btgt[s];
    end
`endif
    chk({tag, ".pc_f"}, pc_f, m_pc);
    chk({tag, ".redirect"}, 32'(redirect), 32'(redir));
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".id_instr"}, id_instr, m_instr);
      chk({tag, ".id_pc"}, id_pc, m_idpc);
      chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_plus4);
      chk({tag, ".id_pred_taken"}, 32'(id_pred_taken), 32'(m_ptaken));
      chk({tag, ".id_pred_target"}, id_pred_target, m_ptgt);
    end
    @(posedge clk);
    if (redir) begin
      m_pc = nxt; m_valid = 1'b0;
    end else if (!stall) begin
      m_valid = 1'b1; m_instr = instr_f; m_idpc = m_pc; m_plus4 = m_pc + 32'd4;
      m_ptaken = ptk; m_ptgt = pnext; m_pc = pnext;
    end
`ifdef PC_FETCH_BTB_EN
    s = int'((ex_pc >> 2) % 16);
    if (ex_valid && ex_taken) begin
      m_bv[s] = 1'b1; m_bpc[s] = ex_pc; m_btgt[s] = tgt;
    end else if (ex_valid && ex_pred_taken) begin
      m_bv[s] = 1'b0;
    end
`endif
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [31:0] dest, input string tag);
    ex_valid = 1'b1; ex_taken = 1'b1; ex_jump_reg = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 32'h0000_0304; ex_rs1 = dest; ex_imm = '0;
    step(tag);
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    do_reset("rst0");

    // Boot sequence from the reset vector
    step("boot0");
    step("boot1");
    #1;
    chk("boot.pc_f", pc_f, 32'h108);
    chk("boot.id_pc", id_pc, 32'h104);
    step("boot2");

    // Backward branch mispredicted as not-taken
    ex_valid = 1'b1; ex_taken = 1'b1; ex_pred_taken = 1'b0;
    ex_pc = 32'h200; ex_imm = 32'hFFFF_FFF0;
    #1;
    chk("br.redirect", 32'(redirect), 32'd1);
    step("br");
    idle();
    #1;
    chk("br.pc_f", pc_f, 32'h1F0);
    chk("br.id_valid", 32'(id_valid), 32'd0);
    step("br.after");

    // jalr redirect beats a simultaneous stall, target bit 0 cleared
    ex_valid = 1'b1; ex_taken = 1'b1; ex_jump_reg = 1'b1; ex_pred_taken = 1'b0;
    ex_rs1 = 32'h1003; ex_imm = 32'd4; stall = 1'b1;
    step("jalr");
    idle();
    #1;
    chk("jalr.pc_f", pc_f, 32'h1006);
    chk("jalr.id_valid", 32'(id_valid), 32'd0);

    // Address wrap at the top of memory
    ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFFC;
    step("wrap.jmp");
    idle();
    step("wrap.fetch");
    #1;
    chk("wrap.pc_f", pc_f, 32'h0);
    chk("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.id_pc_plus4", id_pc_plus4, 32'h0);

    // Stall held three cycles at 0x40 with a live instruction in IF/ID
    ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = 32'h3C; ex_imm = 32'h0;
    step("stl.jmp");
    idle();
    instr_f = 32'hDEAD_BEEF;
    step("stl.fill");
    stall = 1'b1;
    instr_f = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      step("stl.hold");
      chk("stl.pc_f", pc_f, 32'h40);
      chk("stl.id_valid", 32'(id_valid), 32'd1);
      chk("stl.id_instr", id_instr, 32'hDEAD_BEEF);
      chk("stl.id_pc", id_pc, 32'h3C);
      chk("stl.id_pc_plus4", id_pc_plus4, 32'h40);
    end
    stall = 1'b0;
    step("stl.release");
    #1;
    chk("stl.resume_pc", pc_f, 32'h44);
    chk("stl.resume_id_pc", id_pc, 32'h40);

`ifdef PC_FETCH_BTB_EN
    // Train the BTB on 0x80 -> 0x20, then observe prediction and retraining
    ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = 32'h80; ex_imm = 32'hFFFF_FFA0;
    step("btb.train");
    idle();
    jump_to(32'h80, "btb.go80");
    step("btb.fetch80");
    #1;
    chk("btb.pc_f", pc_f, 32'h20);
    chk("btb.id_pred_taken", 32'(id_pred_taken), 32'd1);
    chk("btb.id_pred_target", id_pred_target, 32'h20);
    ex_valid = 1'b1; ex_taken = 1'b1; ex_pc = 32'h80; ex_imm = 32'hFFFF_FFA0;
    ex_pred_taken = 1'b1; ex_pred_target = 32'h20;
    #1;
    chk("btb.correct_pred", 32'(redirect), 32'd0);
    step("btb.resolve");
    ex_taken = 1'b0;
    #1;
    chk("btb.nt_redirect", 32'(redirect), 32'd1);
    step("btb.nt");
    idle();
    #1;
    chk("btb.nt_pc", pc_f, 32'h84);
    jump_to(32'h80, "btb.go80b");
    step("btb.refetch");
    #1;
    chk("btb.invalidated_pc", pc_f, 32'h84);
    chk("btb.invalidated_pred", 32'(id_pred_taken), 32'd0);
`endif

    // Random traffic with one asynchronous reset in the middle
    for (int c = 0; c < 400; c++) begin
      logic [31:0] t;
      if (c == 200) begin
        idle();
        do_reset("rst_mid");
      end
      stall       = ($urandom_range(0, 3) == 0);
      instr_f     = $urandom;
      ex_valid    = ($urandom_range(0, 2) == 0);
      ex_taken    = $urandom_range(0, 1) == 1;
      ex_jump_reg = ($urandom_range(0, 3) == 0);
      ex_pc       = {22'd0, 8'($urandom), 2'b00};
      ex_imm      = 32'($signed(12'($urandom)));
      ex_rs1      = {22'd0, 10'($urandom)};
      ex_pred_taken = $urandom_range(0, 1) == 1;
      t = ex_jump_reg ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
      ex_pred_target = ($urandom_range(0, 1) == 1) ? t : {22'd0, 10'($urandom)};
      step("rnd");
    end
    idle();
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
